// File: rtl/uart_sw_nch.sv
// UART with four elaboration-time baud rates, a TX serializer and an RX deserializer feeding a FWFT FIFO.
// Define UART_PARITY_EN to add a parity bit (sense PARITY_ODD) to both directions.
module uart_sw_nch #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned RATE0      = 115200,
  parameter int unsigned RATE1      = 9600,
  parameter int unsigned RATE2      = 57600,
  parameter int unsigned RATE3      = 19200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    baud_sel,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_start,
  output logic                          tx,
  output logic                          tx_idle,
  output logic                          tx_done,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_rd,
  input  logic                          rx_clr,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overrun,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err
);

  localparam int unsigned PER0    = (CLOCK_FREQ + RATE0 / 2) / RATE0;
  localparam int unsigned PER1    = (CLOCK_FREQ + RATE1 / 2) / RATE1;
  localparam int unsigned PER2    = (CLOCK_FREQ + RATE2 / 2) / RATE2;
  localparam int unsigned PER3    = (CLOCK_FREQ + RATE3 / 2) / RATE3;
  localparam int unsigned PER01   = (PER0 > PER1) ? PER0 : PER1;
  localparam int unsigned PER23   = (PER2 > PER3) ? PER2 : PER3;
  localparam int unsigned PER_MAX = (PER01 > PER23) ? PER01 : PER23;
  localparam int unsigned CW      = $clog2(PER_MAX + 1);
  localparam int unsigned BW      = $clog2(DATA_BITS);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned NW      = AW + 1;

  if (DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || PARITY_ODD > 1)
  begin : g_param_chk
    $error("uart_sw_nch: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  function automatic logic [CW-1:0] sel_per(input logic [1:0] s);
    case (s)
      2'd0:    return CW'(PER0);
      2'd1:    return CW'(PER1);
      2'd2:    return CW'(PER2);
      default: return CW'(PER3);
    endcase
  endfunction

  // ---------------- transmitter ----------------
  state_t               tx_state, tx_state_d;
  logic [CW-1:0]        tx_cnt, tx_cnt_d, tx_per, tx_per_d;
  logic [BW-1:0]        tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_line_d, tx_idle_d, tx_done_d, tx_last;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_per   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_idle  <= 1'b1;
      tx_done  <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_per   <= tx_per_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx       <= tx_line_d;
      tx_idle  <= tx_idle_d;
      tx_done  <= tx_done_d;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_d;
`endif
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_per_d   = tx_per;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_last    = (tx_cnt == tx_per - CW'(1));
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par;
`endif
    case (tx_state)
      S_IDLE: begin
        if (tx_start) begin
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_shift_d = tx_data;
          tx_per_d   = sel_per(baud_sel);
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_data ^ 1'(PARITY_ODD);
`endif
        end
      end
      S_START: begin
        if (tx_last) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt + CW'(1);
      end
      S_DATA: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift >> 1;
          tx_bit_d   = tx_bit + BW'(1);
          if (tx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            tx_state_d = S_PARITY;
`else
            tx_state_d = S_STOP;
`endif
          end
        end else tx_cnt_d = tx_cnt + CW'(1);
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tx_last) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = '0;
        end else tx_cnt_d = tx_cnt + CW'(1);
      end
`endif
      S_STOP: begin
        if (tx_last) tx_state_d = S_IDLE;
        else         tx_cnt_d   = tx_cnt + CW'(1);
      end
      default: tx_state_d = S_IDLE;
    endcase

    case (tx_state_d)
      S_START:  tx_line_d = 1'b0;
      S_DATA:   tx_line_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_line_d = tx_par_d;
`endif
      default:  tx_line_d = 1'b1;
    endcase
    tx_idle_d = (tx_state_d == S_IDLE);
    tx_done_d = (tx_state_d == S_STOP) && (tx_cnt_d == tx_per_d - CW'(1));
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_prev;
  state_t               rx_state, rx_state_d;
  logic [CW-1:0]        rx_cnt, rx_cnt_d, rx_per, rx_per_d;
  logic [BW-1:0]        rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_push, rx_push_d, rx_ferr_ev, rx_ferr_d, rx_last, rx_half;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad, rx_par_bad_d, rx_perr_ev, rx_perr_d;
`endif

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync    <= 2'b11;
      rx_prev    <= 1'b1;
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_per     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_push    <= 1'b0;
      rx_ferr_ev <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad <= 1'b0;
      rx_perr_ev <= 1'b0;
`endif
    end else begin
      rx_sync    <= {rx_sync[0], rx};
      rx_prev    <= rx_s;
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_per     <= rx_per_d;
      rx_bit     <= rx_bit_d;
      rx_shift   <= rx_shift_d;
      rx_push    <= rx_push_d;
      rx_ferr_ev <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_par_bad <= rx_par_bad_d;
      rx_perr_ev <= rx_perr_d;
`endif
    end
  end

  // Start on a falling edge, confirm at half a bit, then sample every bit period.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_per_d   = rx_per;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_push_d  = 1'b0;
    rx_ferr_d  = 1'b0;
    rx_last    = (rx_cnt == rx_per - CW'(1));
    rx_half    = (rx_cnt == (rx_per >> 1) - CW'(1));
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad;
    rx_perr_d    = 1'b0;
`endif
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
          rx_per_d   = sel_per(baud_sel);
        end
      end
      S_START: begin
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end else rx_cnt_d = rx_cnt + CW'(1);
      end
      S_DATA: begin
        if (rx_last) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit + BW'(1);
          if (rx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rx_state_d = S_PARITY;
`else
            rx_state_d = S_STOP;
`endif
          end
        end else rx_cnt_d = rx_cnt + CW'(1);
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (rx_last) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = ((^rx_shift) ^ rx_s) != 1'(PARITY_ODD);
          rx_state_d   = S_STOP;
        end else rx_cnt_d = rx_cnt + CW'(1);
      end
`endif
      S_STOP: begin
        if (rx_last) begin
          rx_state_d = S_IDLE;
          if (!rx_s) rx_ferr_d = 1'b1;
`ifdef UART_PARITY_EN
          else if (rx_par_bad) rx_perr_d = 1'b1;
`endif
          else rx_push_d = 1'b1;
        end else rx_cnt_d = rx_cnt + CW'(1);
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, empty, do_push, do_pop, ovf;
  logic [NW-1:0]        count_nxt;

  assign full      = (rx_count == NW'(FIFO_DEPTH));
  assign empty     = (rx_count == '0);
  assign do_pop    = rx_rd && !empty;
  assign do_push   = rx_push && (!full || do_pop);
  assign ovf       = rx_push && full && !do_pop;
  assign count_nxt = rx_count + NW'(do_push) - NW'(do_pop);
  assign rx_data   = mem[rd_ptr];

  // rx_clr wins over any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_count     <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else if (rx_clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_count     <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= rx_shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      rx_count     <= count_nxt;
      rx_valid     <= (count_nxt != '0);
      rx_overrun   <= rx_overrun | ovf;
      rx_frame_err <= rx_frame_err | rx_ferr_ev;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rx_parity_err <= 1'b0;
    else if (rx_clr) rx_parity_err <= 1'b0;
    else             rx_parity_err <= rx_parity_err | rx_perr_ev;
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
